rr_prio_encoder: RTL and testbench
==================================

# rr_prio_encoder

Registered, parametrised N-to-log2(N) priority encoder with a valid/ack output handshake and an optional round-robin fairness mode. It is the next-generation replacement for the fixed 8x3 combinational priority encoder. It sits between a bank of request lines and a single consumer, such as a bus arbiter or interrupt dispatcher, and presents one encoded winner per handshake.

## Interface
- N, default 8: number of request lines; legal range 2..256; need not be a power of two.
- W, default $clog2(N): index width; derived, not overridden.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  block enable; when low, no new encode and any held output is dropped.
- req  input  N  request vector; bit i set means line i is requesting.
- ack  input  1  consumer accepts the current output; meaningful only while valid=1.
- valid  output  1  idx/grant hold a live result.
- idx  output  W  encoded winning line.
- grant  output  N  one-hot of idx; all zeros when valid=0.

## Operation
- A transfer occurs on a clk edge where valid=1 and ack=1.
- The output register is "free" when valid=0 or a transfer is occurring.
- Per clk edge, in priority order:
  1. rst=1: valid=0, idx=0, grant=0, ptr=0.
  2. en=0: valid=0, grant=0. idx is unchanged. ptr is updated only if a transfer occurs on this edge.
  3. Register free and req≠0: sample req, then valid=1, idx=winner, grant=onehot(winner).
  4. Register free and req=0: valid=0, grant=0, idx unchanged.
  5. valid=1 and ack=0 (stall): idx, grant and valid hold. req changes are ignored.
- Fixed-priority selection: the highest set index wins (bit N-1 highest, bit 0 lowest).
- Round-robin selection (macro enabled):
  - ptr (W bits) holds the index of the last transferred winner.
  - Search order is ptr-1, ptr-2, …, 0, then N-1, …, ptr. The last winner has the lowest priority.
  - The search wraps correctly for non-power-of-two N.
  - ptr is loaded with idx on every transfer.
  - ptr=0 after reset, so the first search order is N-1…0, identical to fixed priority.
- A request withdrawn while its grant is stalled is still presented until ack. The consumer is responsible for tolerating this.
- ack while valid=0 is ignored.

## Timing
- Latency: 1 cycle from req sampled on a free edge to valid/idx/grant.
- Back-to-back throughput: one result per cycle when ack is held high and req≠0.
- Reset is synchronous. rst asserted mid-stall clears valid and ptr on that edge; no transfer is counted.
- All outputs come directly from flops; there is no combinational path from req or ack to any output.
- Reset values: valid=0, idx=0, grant=0, ptr=0.

## Configuration
- Macro: RR_PRIO_ENCODER_RR_EN.
- Defined: the round-robin pointer and rotated search are compiled in.
- Undefined: there is no ptr register, and selection is fixed highest-index priority. Port list and handshake are identical in both builds.

## Structure
- Package prio_enc_pkg holds:
  - the clog2-based width helper;
  - the function onehot(idx, N);
  - the reset-value constants.
- Sub-module prio_find_msb: purely combinational, parametrised on N. Outputs found and the highest set index.
  - Fixed mode uses one instance on req.
  - RR mode uses two instances: one on req masked to indices below ptr, one on unmasked req. The masked result wins when found.

## Test plan
- Reset: hold rst=1 for 2 cycles with en=1, req=8'hFF → valid=0, idx=0, grant=0. After release, the first result is idx=7.
- Basic encode, N=8: en=1, ack=1, req=8'b0010_0001 → next cycle valid=1, idx=5, grant=8'b0010_0000. Then req=0 → valid=0 the following cycle.
- Stall: result idx=5 live, ack=0 for 3 cycles, req switched to 8'b1000_0000 → idx=5 and grant held for all 3 cycles. On ack=1, the next result is idx=7.
- Rotation: req=8'b1010_0100 held, ack=1 continuously.
  - With RR_PRIO_ENCODER_RR_EN: idx sequence is 7,5,2,7,5.
  - Without it: 7,7,7,7,7.
- en drop: stall with idx=2, then en=0 for 1 cycle → valid=0 next edge. With en=1 again, req=8'b1010_0100 → RR build gives idx=7, since ptr was not updated by the dropped grant.
- Odd width, N=5, RR build: req=5'b10011, ack=1 → idx sequence 4,1,0,4; wrap is correct and idx never reaches 5..7.

Source files
------------

// File: rtl/rr_prio_encoder_pkg.sv
// Shared definitions for rr_prio_encoder: index-width helper, one-hot helper,
// reset values and the per-edge update action.
package prio_enc_pkg;

  localparam int unsigned MAX_N = 256;

  typedef enum logic [1:0] {
    ACT_DROP,
    ACT_LOAD,
    ACT_EMPTY,
    ACT_HOLD
  } action_e;

  localparam logic             RST_VALID = 1'b0;
  localparam int unsigned      RST_IDX   = 0;
  localparam int unsigned      RST_PTR   = 0;
  localparam logic [MAX_N-1:0] RST_GRANT = '0;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [MAX_N-1:0] onehot(input int unsigned idx, input int unsigned n);
    logic [MAX_N-1:0] r;
    r = '0;
    if (idx < n) r = MAX_N'(1) << idx;
    return r;
  endfunction

endpackage

// File: rtl/rr_prio_encoder_if.sv
// Request/result handshake bundle between a request bank and the encoder.
interface rr_prio_encoder_if #(
  parameter int unsigned N = 8
) ();
  import prio_enc_pkg::*;

  localparam int unsigned W = idx_width(N);

  logic         en;
  logic [N-1:0] req;
  logic         ack;
  logic         valid;
  logic [W-1:0] idx;
  logic [N-1:0] grant;

  modport master (output en, req, ack, input valid, idx, grant);
  modport slave  (input en, req, ack, output valid, idx, grant);
endinterface

// File: rtl/rr_prio_encoder_find_msb.sv
// Combinational search for the highest set bit of an N-bit vector.
module prio_find_msb #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 3
) (
  input  logic [N-1:0] req_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req_i[i]) begin
        found_o = 1'b1;
        idx_o   = W'(i);
      end
    end
  end

endmodule

// File: rtl/rr_prio_encoder.sv
// Registered N-to-log2(N) priority encoder with valid/ack output handshake.
// Define RR_PRIO_ENCODER_RR_EN to build the round-robin (last winner lowest) variant.
module rr_prio_encoder
  import prio_enc_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input logic              clk,
  input logic              rst,
  rr_prio_encoder_if.slave bus
);

  localparam int unsigned W = idx_width(N);

  logic         valid_q, valid_d;
  logic [W-1:0] idx_q, idx_d;
  logic [N-1:0] grant_q, grant_d;
  logic         free;
  logic         found;
  logic [W-1:0] win;
  action_e      act;

  assign free = ~valid_q | bus.ack;

`ifdef RR_PRIO_ENCODER_RR_EN
  logic         xfer;
  logic [W-1:0] ptr_q, ptr_d, ptr_eff;
  logic [N-1:0] below;
  logic         lo_found;
  logic [W-1:0] lo_idx, all_idx;

  // The winner being accepted on this edge already counts as "last winner"
  // for the selection loaded on the same edge.
  assign xfer    = valid_q & bus.ack;
  assign ptr_eff = xfer ? idx_q : ptr_q;
  assign ptr_d   = ptr_eff;

  always_comb begin
    below = '0;
    for (int unsigned i = 0; i < N; i++) begin
      below[i] = (i < 32'(ptr_eff));
    end
  end

  prio_find_msb #(.N(N), .W(W)) u_find_lo (
    .req_i   (bus.req & below),
    .found_o (lo_found),
    .idx_o   (lo_idx)
  );

  prio_find_msb #(.N(N), .W(W)) u_find_all (
    .req_i   (bus.req),
    .found_o (found),
    .idx_o   (all_idx)
  );

  assign win = lo_found ? lo_idx : all_idx;

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= W'(RST_PTR);
    else     ptr_q <= ptr_d;
  end
`else
  prio_find_msb #(.N(N), .W(W)) u_find (
    .req_i   (bus.req),
    .found_o (found),
    .idx_o   (win)
  );
`endif

  always_comb begin
    act = ACT_HOLD;
    if (!bus.en)   act = ACT_DROP;
    else if (free) act = found ? ACT_LOAD : ACT_EMPTY;

    valid_d = valid_q;
    idx_d   = idx_q;
    grant_d = grant_q;
    case (act)
      ACT_DROP, ACT_EMPTY: begin
        valid_d = 1'b0;
        grant_d = '0;
      end
      ACT_LOAD: begin
        valid_d = 1'b1;
        idx_d   = win;
        grant_d = N'(onehot(32'(win), N));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= RST_VALID;
      idx_q   <= W'(RST_IDX);
      grant_q <= N'(RST_GRANT);
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
    end
  end

  assign bus.valid = valid_q;
  assign bus.idx   = idx_q;
  assign bus.grant = grant_q;

endmodule

// File: tb/tb_rr_prio_encoder.sv
// Bench for rr_prio_encoder: directed vector table, N=5 wrap sequence, and
// randomized traffic against a search-order reference model (N=8 and N=5).
module tb_rr_prio_encoder;

`ifdef RR_PRIO_ENCODER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_prio_encoder_if #(.N(8)) bus8 ();
  rr_prio_encoder_if #(.N(5)) bus5 ();

  rr_prio_encoder #(.N(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  rr_prio_encoder #(.N(5)) dut5 (.clk(clk), .rst(rst), .bus(bus5.slave));

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          valid;
    int unsigned idx;
    int unsigned ptr;
  } mstate_t;

  mstate_t m8, m5;

  typedef struct {
    bit          r, e, a;
    logic [7:0]  q;
    bit          ev;
    int unsigned efix, err;
  } vec_t;

  vec_t tbl[$];

  // Search ptr-1, ptr-2, ..., wrapping modulo n; ptr itself is tried last.
  function automatic int unsigned pick(logic [7:0] q, int unsigned ptr, int unsigned n);
    for (int unsigned k = 1; k <= n; k++) begin
      int unsigned c;
      c = (ptr + n - k) % n;
      if (q[c]) return c;
    end
    return 0;
  endfunction

  function automatic mstate_t mnext(mstate_t s, bit r, bit e, bit a, logic [7:0] q, int unsigned n);
    mstate_t t;
    t = s;
    if (r) begin
      t.valid = 1'b0; t.idx = 0; t.ptr = 0;
      return t;
    end
    if (RR && s.valid && a) t.ptr = s.idx;
    if (!e) t.valid = 1'b0;
    else if (!s.valid || a) begin
      if (q != 8'd0) begin
        t.valid = 1'b1;
        t.idx   = pick(q, t.ptr, n);
      end else begin
        t.valid = 1'b0;
      end
    end
    return t;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(bit r, bit e, bit a, logic [7:0] q8, logic [4:0] q5);
    rst      = r;
    bus8.en  = e; bus8.ack = a; bus8.req = q8;
    bus5.en  = e; bus5.ack = a; bus5.req = q5;
    @(posedge clk);
    m8 = mnext(m8, r, e, a, q8, 8);
    m5 = mnext(m5, r, e, a, {3'b000, q5}, 5);
    #1;
  endtask

  task automatic add(bit r, bit e, bit a, logic [7:0] q, bit ev, int unsigned efix, int unsigned err);
    vec_t v;
    v.r = r; v.e = e; v.a = a; v.q = q; v.ev = ev; v.efix = efix; v.err = err;
    tbl.push_back(v);
  endtask

  task automatic check_model(string tag);
    check({tag, " valid8"}, 32'(bus8.valid), 32'(m8.valid));
    check({tag, " idx8"},   32'(bus8.idx),   m8.valid ? m8.idx : 32'(bus8.idx));
    check({tag, " grant8"}, 32'(bus8.grant), m8.valid ? (32'd1 << m8.idx) : 32'd0);
    check({tag, " valid5"}, 32'(bus5.valid), 32'(m5.valid));
    check({tag, " idx5"},   32'(bus5.idx),   m5.valid ? m5.idx : 32'(bus5.idx));
    check({tag, " grant5"}, 32'(bus5.grant), m5.valid ? (32'd1 << m5.idx) : 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned seq_rr [4];
    int unsigned e;
    logic [7:0]  q8;
    logic [4:0]  q5;

    rst = 1'b1;
    bus8.en = 1'b0; bus8.ack = 1'b0; bus8.req = '0;
    bus5.en = 1'b0; bus5.ack = 1'b0; bus5.req = '0;
    m8 = '{1'b0, 0, 0};
    m5 = '{1'b0, 0, 0};

    //   r  e  a  req      ev fix rr
    add(1, 1, 1, 8'hFF,   0, 0, 0);   // reset held with all requests
    add(1, 1, 1, 8'hFF,   0, 0, 0);
    add(0, 1, 1, 8'hFF,   1, 7, 7);
    add(0, 1, 1, 8'h21,   1, 5, 5);   // basic encode
    add(0, 1, 1, 8'h00,   0, 5, 5);
    add(1, 1, 1, 8'h00,   0, 0, 0);
    add(0, 1, 0, 8'h21,   1, 5, 5);   // stall: req change ignored
    add(0, 1, 0, 8'h80,   1, 5, 5);
    add(0, 1, 0, 8'h80,   1, 5, 5);
    add(0, 1, 0, 8'h80,   1, 5, 5);
    add(0, 1, 1, 8'h80,   1, 7, 7);
    add(0, 1, 1, 8'h00,   0, 7, 7);
    add(1, 1, 1, 8'h00,   0, 0, 0);
    add(0, 1, 1, 8'hA4,   1, 7, 7);   // rotation
    add(0, 1, 1, 8'hA4,   1, 7, 5);
    add(0, 1, 1, 8'hA4,   1, 7, 2);
    add(0, 1, 1, 8'hA4,   1, 7, 7);
    add(0, 1, 1, 8'hA4,   1, 7, 5);
    add(0, 1, 1, 8'h00,   0, 7, 5);
    add(1, 1, 1, 8'h00,   0, 0, 0);
    add(0, 1, 0, 8'h04,   1, 2, 2);   // en drop of a stalled grant
    add(0, 1, 0, 8'h04,   1, 2, 2);
    add(0, 0, 0, 8'hA4,   0, 2, 2);
    add(0, 1, 1, 8'hA4,   1, 7, 7);
    add(0, 1, 1, 8'h00,   0, 7, 7);
    add(0, 1, 0, 8'h80,   1, 7, 7);   // reset mid-stall, ack high
    add(1, 1, 1, 8'h80,   0, 0, 0);
    add(0, 1, 1, 8'hA4,   1, 7, 7);
    add(0, 1, 1, 8'hA4,   1, 7, 5);
    add(0, 1, 1, 8'h00,   0, 7, 5);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].a, tbl[i].q, tbl[i].q[4:0]);
      e = RR ? tbl[i].err : tbl[i].efix;
      check($sformatf("vec%0d valid", i), 32'(bus8.valid), 32'(tbl[i].ev));
      check($sformatf("vec%0d idx", i),   32'(bus8.idx),   e);
      check($sformatf("vec%0d grant", i), 32'(bus8.grant), tbl[i].ev ? (32'd1 << e) : 32'd0);
    end

    // N=5 wrap: 4,1,0,4 when rotating, 4 every time otherwise
    seq_rr = '{4, 1, 0, 4};
    step(1, 1, 1, 8'h00, 5'b00000);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1, 8'h00, 5'b10011);
      e = RR ? seq_rr[i] : 4;
      check($sformatf("n5 seq%0d valid", i), 32'(bus5.valid), 32'd1);
      check($sformatf("n5 seq%0d idx", i),   32'(bus5.idx),   e);
      check($sformatf("n5 seq%0d grant", i), 32'(bus5.grant), 32'd1 << e);
    end

    for (int i = 0; i < 1500; i++) begin
      q8 = ($urandom % 4 == 0) ? 8'h00 : 8'($urandom);
      q5 = ($urandom % 4 == 0) ? 5'h00 : 5'($urandom);
      step($urandom_range(0, 99) == 0, ($urandom % 10) != 0, ($urandom % 3) != 0, q8, q5);
      check_model($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
